i2c_apb_master: RTL and testbench
=================================

# i2c_apb_master

Upstream stage of the I2C-to-APB bridge: an I2C target front end that decodes I2C write/read transfers from an external controller and turns each data byte into one APB transfer on the 7-bit-address, 8-bit-data APB bus served by `apb_slave`. It supports a register pointer with auto-increment, SCL clock stretching while an APB transfer is in flight, and ACK/NACK signalling of address and slave errors.

## Interface

Parameters:
- `DEV_ADDR`, 7'h50: I2C target address this block answers to.

Ports:
- `clk`: input, 1 bit. System clock; must be ≥ 16× SCL frequency.
- `rst`: input, 1 bit. Reset, asynchronous, active-low.
- `scl_in`: input, 1 bit. I2C SCL pad input, asynchronous.
- `sda_in`: input, 1 bit. I2C SDA pad input, asynchronous.
- `scl_oe`: output, 1 bit. 1 pulls SCL low (stretch). Open-drain.
- `sda_oe`: output, 1 bit. 1 pulls SDA low. Open-drain.
- `apb_paddr`: output, 7 bits. APB address.
- `apb_pwrite`: output, 1 bit. APB write strobe.
- `apb_pread`: output, 1 bit. APB read strobe.
- `apb_penable`: output, 1 bit. APB access phase.
- `apb_pwdata`: output, 8 bits. APB write data.
- `apb_prdata`: input, 8 bits. APB read data.
- `apb_pready`: input, 1 bit. APB transfer complete.
- `apb_pslverr`: input, 1 bit. APB slave error, valid with `apb_pready`.
- `busy`: output, 1 bit. High from an addressed START to STOP or NACK.
- `err`: output, 1 bit. One-cycle pulse on any NACKed byte or APB error.

## Operation

- **Input conditioning.** `scl_in` and `sda_in` each pass through a 2-flop synchronizer, then a registered edge detector.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START or STOP in any state forces the state machine to its entry point (`DEV_ADDR` or `IDLE`).
- **States:** `IDLE`, `DEV_ADDR`, `DEV_ACK`, `REG_ADDR`, `REG_ACK`, `WR_DATA`, `WR_APB`, `WR_ACK`, `RD_APB`, `RD_SEND`, `RD_MACK`, `WAIT_STOP`.
- **Bit sampling.** Bits are sampled MSB first on the SCL rising edge. SDA is changed only after an SCL falling edge.
- **DEV_ADDR.** Shift in 8 bits.
  - Upper 7 bits ≠ `DEV_ADDR`: do not ACK, go to `WAIT_STOP`. No `err` pulse.
  - Match: ACK. R/W=0 goes to `REG_ADDR`. R/W=1 goes to `RD_APB`.
- **REG_ADDR.** Receive one byte.
  - bit7=1: NACK, pulse `err`, go to `WAIT_STOP`.
  - Otherwise: pointer ← bits[6:0], ACK, go to `WR_DATA`.
- **WR_DATA.** On the SCL falling edge after bit 8:
  - Assert `scl_oe`.
  - Enter `WR_APB`: one setup cycle (`apb_paddr`=pointer, `apb_pwrite`=1, `apb_pwdata`=byte, `apb_penable`=0).
  - Then the access phase with `apb_penable`=1, held until `apb_pready`.
- **WR_APB result.**
  - `apb_pslverr`=0: ACK, pointer+1.
  - `apb_pslverr`=1: NACK, pulse `err`, pointer unchanged.
  - Drive the ACK/NACK on SDA, then release `scl_oe`.
  - The controller may send further data bytes; each repeats this sequence.
- **RD_APB.** Hold SCL low and issue an APB read of the pointer (setup cycle with `apb_pread`=1, then the access phase).
  - At `apb_pready`: load the shift register with `apb_prdata`, or with 8'hFF plus an `err` pulse if `apb_pslverr`=1.
  - Pointer+1 on success only.
  - Release SCL and go to `RD_SEND`.
- **RD_SEND.** Drive 8 bits: `sda_oe` = ~bit.
- **RD_MACK.** Release SDA and sample the controller ACK.
  - ACK: go to `RD_APB` for the next byte.
  - NACK: go to `WAIT_STOP`. No prefetch, so there is no extra APB read.
- **Pointer.** 7 bits, wraps 127→0. Retained across transfers, so a read with no preceding register byte uses the last pointer value. Reset value 0.
- **Repeated START.** Keeps the pointer. Re-enters `DEV_ADDR`.
- **Strobes.** Only one of `apb_pwrite`/`apb_pread` is high at a time. Both are low outside `WR_APB`/`RD_APB`.

## Timing

- **Reset values:** all outputs 0; state `IDLE`; pointer 0; shift register 0.
- **Input latency:** 3 clk from a pad edge to a detected event.
- **APB transfer:** 1 setup cycle plus N access cycles (N ≥ 1, up to the cycle `apb_pready` is seen high). APB outputs drop to 0 the cycle after `apb_pready`.
- **Stretch window:** asserted on the first clk after the detected SCL fall; released 1 clk after `apb_pready` once SDA is set up. Minimum 3 clk.
- **SDA changes:** 1 clk after the detected SCL fall, never while SCL is high except for START/STOP.
- **START/STOP mid-APB:** the APB transfer in flight completes, its result is discarded, `scl_oe`/`sda_oe` are released, then the state updates.
- **`rst` asserted mid-transfer:** all outputs drop immediately (asynchronously). After release, the block waits for a new START.

## Test plan

- START, 0xA0, 0x32, 0xAA, 0xAB, STOP → all bytes ACKed; APB writes addr 50=0xAA, then 51=0xAB; SCL stretched during each.
- START, 0xA0, 0x32, Sr, 0xA1, read 2 bytes (ACK, NACK), STOP → SDA returns 0xAA, 0xAB; exactly 2 APB reads (addr 50, 51); no third read.
- START, 0xA2 (address 0x51) → no ACK, no APB activity, `busy` low, `err` low.
- START, 0xA0, 0x82 → register byte NACKed, `err` pulses once, no APB transfer.
- Write to 0x7F with `apb_pslverr`=1 on the first byte, 0 on the second → first byte NACKed with `err` pulse; retry is ACKed at addr 0x7F; next byte goes to addr 0x00 (wrap).
- `rst` low during an `RD_APB` with `apb_pready` held low → `scl_oe`, `sda_oe` and APB outputs 0 immediately; a new write after release works.

Source files
------------

// File: rtl/i2c_apb_master.sv
`timescale 1ns/1ps
// I2C target that turns each received/sent data byte into one APB write/read at an auto-incrementing pointer.
// Latency: 3 clk pad-to-event, then 1 APB setup cycle plus access cycles until apb_pready.
// Backpressure: SCL is stretched from the byte's last falling edge until the APB result is on SDA.
module i2c_apb_master #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [6:0] apb_paddr,
    output logic       apb_pwrite,
    output logic       apb_pread,
    output logic       apb_penable,
    output logic [7:0] apb_pwdata,
    input  logic [7:0] apb_prdata,
    input  logic       apb_pready,
    input  logic       apb_pslverr,
    output logic       busy,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_REG_ADDR, S_REG_ACK, S_WR_DATA,
        S_WR_APB, S_WR_ACK, S_RD_APB, S_RD_SEND, S_RD_MACK, S_WAIT_STOP
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q, scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [6:0] ptr, ptr_nxt;
    logic       rw, rw_nxt, mack, mack_nxt, done, done_nxt;
    logic       pend_vld, pend_vld_nxt, pend_start, pend_start_nxt;
    logic       scl_oe_nxt, sda_oe_nxt, pwrite_nxt, pread_nxt, penable_nxt, busy_nxt, err_nxt;
    logic [6:0] paddr_nxt;
    logic [7:0] pwdata_nxt;
    logic       evt_go, evt_start, in_flight, apb_fin, byte_done;

    // Synchronizers idle high so a reset release never looks like bus activity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[0], scl_in};
            sda_sync  <= {sda_sync[0], sda_in};
            scl_q     <= scl_sync[1];
            sda_q     <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_q;
            scl_fall  <= ~scl_sync[1] & scl_q;
            start_det <= scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            mack        <= 1'b0;
            done        <= 1'b0;
            pend_vld    <= 1'b0;
            pend_start  <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            apb_paddr   <= '0;
            apb_pwrite  <= 1'b0;
            apb_pread   <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwdata  <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            ptr         <= ptr_nxt;
            rw          <= rw_nxt;
            mack        <= mack_nxt;
            done        <= done_nxt;
            pend_vld    <= pend_vld_nxt;
            pend_start  <= pend_start_nxt;
            scl_oe      <= scl_oe_nxt;
            sda_oe      <= sda_oe_nxt;
            apb_paddr   <= paddr_nxt;
            apb_pwrite  <= pwrite_nxt;
            apb_pread   <= pread_nxt;
            apb_penable <= penable_nxt;
            apb_pwdata  <= pwdata_nxt;
            busy        <= busy_nxt;
            err         <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        ptr_nxt        = ptr;
        rw_nxt         = rw;
        mack_nxt       = mack;
        done_nxt       = 1'b0;
        pend_vld_nxt   = pend_vld;
        pend_start_nxt = pend_start;
        scl_oe_nxt     = scl_oe;
        sda_oe_nxt     = sda_oe;
        paddr_nxt      = apb_paddr;
        pwrite_nxt     = apb_pwrite;
        pread_nxt      = apb_pread;
        penable_nxt    = apb_penable;
        pwdata_nxt     = apb_pwdata;
        busy_nxt       = busy;
        err_nxt        = 1'b0;
        evt_go         = 1'b0;
        evt_start      = 1'b0;
        byte_done      = scl_fall && (bit_cnt == 4'd8);
        apb_fin        = apb_penable & apb_pready;
        in_flight      = (apb_pwrite | apb_pread) & ~apb_fin;

        if ((state == S_DEV_ADDR || state == S_REG_ADDR || state == S_WR_DATA) && scl_rise) begin
            shift_nxt   = {shift[6:0], sda_q};
            bit_cnt_nxt = bit_cnt + 4'd1;
        end

        case (state)
            S_DEV_ADDR: if (byte_done) begin
                if (shift[7:1] == DEV_ADDR) begin
                    rw_nxt     = shift[0];
                    sda_oe_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_DEV_ACK;
                end else begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_WAIT_STOP;
                end
            end
            S_DEV_ACK: if (scl_fall) begin
                sda_oe_nxt = 1'b0;
                if (rw) begin
                    scl_oe_nxt = 1'b1;
                    pread_nxt  = 1'b1;
                    paddr_nxt  = ptr;
                    state_nxt  = S_RD_APB;
                end else begin
                    bit_cnt_nxt = '0;
                    state_nxt   = S_REG_ADDR;
                end
            end
            S_REG_ADDR: if (byte_done) begin
                if (shift[7]) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_WAIT_STOP;
                end else begin
                    ptr_nxt    = shift[6:0];
                    sda_oe_nxt = 1'b1;
                    state_nxt  = S_REG_ACK;
                end
            end
            S_REG_ACK, S_WR_ACK: if (scl_fall) begin
                sda_oe_nxt  = 1'b0;
                bit_cnt_nxt = '0;
                state_nxt   = S_WR_DATA;
            end
            S_WR_DATA: if (byte_done) begin
                scl_oe_nxt = 1'b1;
                pwrite_nxt = 1'b1;
                paddr_nxt  = ptr;
                pwdata_nxt = shift;
                state_nxt  = S_WR_APB;
            end
            S_WR_APB, S_RD_APB: begin
                if (apb_fin) begin
                    pwrite_nxt  = 1'b0;
                    pread_nxt   = 1'b0;
                    penable_nxt = 1'b0;
                    paddr_nxt   = '0;
                    pwdata_nxt  = '0;
                    if (pend_vld) begin
                        // A START/STOP arrived mid-transfer: drop the result and follow the bus
                        evt_go    = 1'b1;
                        evt_start = pend_start;
                    end else begin
                        done_nxt = 1'b1;
                        if (state == S_WR_APB) begin
                            if (apb_pslverr) begin
                                err_nxt = 1'b1;
                            end else begin
                                sda_oe_nxt = 1'b1;
                                ptr_nxt    = ptr + 7'd1;
                            end
                        end else if (apb_pslverr) begin
                            shift_nxt  = 8'hFF;
                            sda_oe_nxt = 1'b0;
                            err_nxt    = 1'b1;
                        end else begin
                            shift_nxt  = apb_prdata;
                            sda_oe_nxt = ~apb_prdata[7];
                            ptr_nxt    = ptr + 7'd1;
                        end
                    end
                end else if (apb_pwrite | apb_pread) begin
                    penable_nxt = 1'b1;
                end else if (done) begin
                    scl_oe_nxt  = 1'b0;
                    bit_cnt_nxt = '0;
                    state_nxt   = (state == S_WR_APB) ? S_WR_ACK : S_RD_SEND;
                end
            end
            S_RD_SEND: if (scl_fall) begin
                if (bit_cnt == 4'd7) begin
                    sda_oe_nxt = 1'b0;
                    state_nxt  = S_RD_MACK;
                end else begin
                    shift_nxt   = {shift[6:0], 1'b0};
                    sda_oe_nxt  = ~shift[6];
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end
            end
            S_RD_MACK: begin
                if (scl_rise) begin
                    mack_nxt = ~sda_q;
                end
                if (scl_fall) begin
                    if (mack) begin
                        scl_oe_nxt = 1'b1;
                        pread_nxt  = 1'b1;
                        paddr_nxt  = ptr;
                        state_nxt  = S_RD_APB;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = S_WAIT_STOP;
                    end
                end
            end
            default: ;
        endcase

        if (start_det || stop_det) begin
            if (in_flight) begin
                pend_vld_nxt   = 1'b1;
                pend_start_nxt = start_det;
            end else begin
                evt_go    = 1'b1;
                evt_start = start_det;
            end
        end

        if (evt_go) begin
            state_nxt    = evt_start ? S_DEV_ADDR : S_IDLE;
            bit_cnt_nxt  = '0;
            ptr_nxt      = ptr;
            err_nxt      = 1'b0;
            done_nxt     = 1'b0;
            pend_vld_nxt = 1'b0;
            scl_oe_nxt   = 1'b0;
            sda_oe_nxt   = 1'b0;
            pwrite_nxt   = 1'b0;
            pread_nxt    = 1'b0;
            penable_nxt  = 1'b0;
            paddr_nxt    = '0;
            pwdata_nxt   = '0;
            if (!evt_start) begin
                busy_nxt = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_apb_master.sv
`timescale 1ns/1ps
// Bench: bit-banged I2C controller plus APB target model; expected APB transfers are queued
// with the stimulus and popped by an independent monitor on every completed access.
module tb_i2c_apb_master;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
    } apb_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl_low = 1'b0;
    logic       m_sda_low = 1'b0;
    logic       scl_bus, sda_bus;
    logic       scl_oe, sda_oe;
    logic [6:0] apb_paddr;
    logic       apb_pwrite, apb_pread, apb_penable;
    logic [7:0] apb_pwdata;
    logic [7:0] apb_prdata;
    logic       apb_pready, apb_pslverr;
    logic       busy, err;
    logic       stall = 1'b0;

    apb_exp_t   exp_q[$];
    logic       slv_q[$];
    logic [7:0] mem[128];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         err_cnt = 0;

    assign scl_bus = ~(m_scl_low | scl_oe);
    assign sda_bus = ~(m_sda_low | sda_oe);

    always #5 clk = ~clk;

    i2c_apb_master #(.DEV_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_bus), .sda_in(sda_bus),
        .scl_oe(scl_oe), .sda_oe(sda_oe),
        .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_pread(apb_pread),
        .apb_penable(apb_penable), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr), .busy(busy), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_apb(input logic wr, input logic [6:0] a, input logic [7:0] d);
        apb_exp_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // APB target: one wait cycle, then pready; slverr taken from slv_q
    initial begin
        int wcnt;
        wcnt = 0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (apb_pready) begin
                apb_pready  = 1'b0;
                apb_pslverr = 1'b0;
                apb_prdata  = 8'h00;
                wcnt = 0;
            end else if (apb_penable && !stall) begin
                if (wcnt >= 1) begin
                    apb_pready  = 1'b1;
                    apb_pslverr = (slv_q.size() != 0) ? slv_q.pop_front() : 1'b0;
                    if (apb_pread) apb_prdata = mem[apb_paddr];
                    else if (!apb_pslverr) mem[apb_paddr] = apb_pwdata;
                end else begin
                    wcnt++;
                end
            end else if (!apb_penable) begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every completed APB access must match the head of the scoreboard
    initial begin
        apb_exp_t e;
        forever begin
            @(negedge clk);
            if (err) err_cnt++;
            if (apb_penable && apb_pready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL apb_unexpected: got wr=%0b rd=%0b addr=%0h, expected no transfer",
                             apb_pwrite, apb_pread, apb_paddr);
                end else begin
                    e = exp_q.pop_front();
                    check("apb_dir", {apb_pwrite, apb_pread}, e.wr ? 2'b10 : 2'b01);
                    check("apb_addr", apb_paddr, e.addr);
                    if (e.wr) check("apb_wdata", apb_pwdata, e.data);
                    check("apb_stretch", scl_oe, 1);
                end
            end
        end
    end

    task automatic wait_scl_high();
        int n;
        n = 0;
        while (scl_bus !== 1'b1 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (scl_bus !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL scl_release: SCL low after %0d clk, expected high", n);
        end
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; #100;
        m_scl_low = 1'b0; wait_scl_high(); #100;
        m_sda_low = 1'b1; #100;
        m_scl_low = 1'b1; #100;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; #100;
        m_scl_low = 1'b0; wait_scl_high(); #100;
        m_sda_low = 1'b0; #200;
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; #100;
        m_scl_low = 1'b0; wait_scl_high(); #200;
        m_scl_low = 1'b1; #100;
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; #100;
        m_scl_low = 1'b0; wait_scl_high(); #100;
        b = sda_bus; #100;
        m_scl_low = 1'b1; #100;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(~ack);
    endtask

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: run exceeded 500 us, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         e0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_oe", {scl_oe, sda_oe}, 0);
        check("rst_apb", {apb_paddr, apb_pwrite, apb_pread, apb_penable, apb_pwdata}, 0);
        check("rst_busy_err", {busy, err}, 0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);

        // T1: two writes at 0x32/0x33
        e0 = err_cnt;
        i2c_start();
        wr_byte(8'hA0, ack); check("t1_addr_ack", ack, 1); check("t1_busy", busy, 1);
        wr_byte(8'h32, ack); check("t1_reg_ack", ack, 1);
        expect_apb(1'b1, 7'h32, 8'hAA);
        wr_byte(8'hAA, ack); check("t1_d0_ack", ack, 1);
        expect_apb(1'b1, 7'h33, 8'hAB);
        wr_byte(8'hAB, ack); check("t1_d1_ack", ack, 1);
        i2c_stop();
        check("t1_busy_after", busy, 0);
        check("t1_err", err_cnt - e0, 0);
        check("t1_apb_left", exp_q.size(), 0);

        // T2: pointer set, repeated START, read two bytes
        i2c_start();
        wr_byte(8'hA0, ack); check("t2_addr_ack", ack, 1);
        wr_byte(8'h32, ack); check("t2_reg_ack", ack, 1);
        i2c_start();
        expect_apb(1'b0, 7'h32, 8'h00);
        expect_apb(1'b0, 7'h33, 8'h00);
        wr_byte(8'hA1, ack); check("t2_raddr_ack", ack, 1);
        rd_byte(d, 1'b1); check("t2_rd0", d, 8'hAA);
        rd_byte(d, 1'b0); check("t2_rd1", d, 8'hAB);
        i2c_stop();
        repeat (20) @(posedge clk);
        check("t2_apb_left", exp_q.size(), 0);

        // T3: wrong device address
        e0 = err_cnt;
        i2c_start();
        wr_byte(8'hA2, ack); check("t3_nack", ack, 0); check("t3_busy", busy, 0);
        i2c_stop();
        check("t3_err", err_cnt - e0, 0);

        // T4: register byte with bit7 set
        e0 = err_cnt;
        i2c_start();
        wr_byte(8'hA0, ack); check("t4_addr_ack", ack, 1);
        wr_byte(8'h82, ack); check("t4_reg_nack", ack, 0);
        check("t4_err", err_cnt - e0, 1);
        check("t4_busy", busy, 0);
        i2c_stop();

        // T5: slave error then retry at 0x7F, next byte wraps to 0x00
        e0 = err_cnt;
        i2c_start();
        wr_byte(8'hA0, ack); check("t5_addr_ack", ack, 1);
        wr_byte(8'h7F, ack); check("t5_reg_ack", ack, 1);
        slv_q.push_back(1'b1);
        expect_apb(1'b1, 7'h7F, 8'h11);
        wr_byte(8'h11, ack); check("t5_slverr_nack", ack, 0);
        check("t5_err_pulse", err_cnt - e0, 1);
        expect_apb(1'b1, 7'h7F, 8'h11);
        wr_byte(8'h11, ack); check("t5_retry_ack", ack, 1);
        expect_apb(1'b1, 7'h00, 8'h22);
        wr_byte(8'h22, ack); check("t5_wrap_ack", ack, 1);
        i2c_stop();
        check("t5_err_total", err_cnt - e0, 1);
        check("t5_apb_left", exp_q.size(), 0);

        // T6: reset while a read waits on pready
        stall = 1'b1;
        i2c_start();
        wr_byte(8'hA1, ack); check("t6_addr_ack", ack, 1);
        repeat (15) @(posedge clk);
        #1;
        check("t6_rd_pending", {apb_pread, apb_penable, scl_oe}, 3'b111);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_oe", {scl_oe, sda_oe}, 0);
        check("t6_rst_apb", {apb_paddr, apb_pwrite, apb_pread, apb_penable, apb_pwdata}, 0);
        check("t6_rst_busy", busy, 0);
        m_scl_low = 1'b0;
        m_sda_low = 1'b0;
        stall = 1'b0;
        #100;
        @(negedge clk) rst = 1'b1;
        repeat (5) @(posedge clk);
        i2c_start();
        wr_byte(8'hA0, ack); check("t6_post_addr_ack", ack, 1);
        wr_byte(8'h10, ack); check("t6_post_reg_ack", ack, 1);
        expect_apb(1'b1, 7'h10, 8'h55);
        wr_byte(8'h55, ack); check("t6_post_data_ack", ack, 1);
        i2c_stop();
        repeat (20) @(posedge clk);
        check("t6_apb_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
